// File: rtl/window_streamer.sv
// Window source: burst-loads an IMG_W x IMG_H image into a pixel buffer, then streams every WIN x WIN window.
// Define WINDOW_STREAMER_STATS_EN to add the saturating transfer counter output win_count.
module window_streamer #(
   parameter int IMG_W        = 80,
   parameter int IMG_H        = 80,
   parameter int WIN          = 16,
   parameter int STRIDE       = 16,
   parameter int PIX_W        = 8,
   parameter int PIX_PER_WORD = 4,
   parameter int ADDR_W       = 21
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [ADDR_W-1:0]          base_addr,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [31:0]                mem_rd_data,
   output logic                       window_valid,
   input  logic                       window_ready,
   output logic [WIN*WIN*PIX_W-1:0]   window_data,
   output logic [6:0]                 win_row,
   output logic [6:0]                 win_col,
   output logic                       busy,
   output logic                       done
`ifdef WINDOW_STREAMER_STATS_EN
   ,output logic [15:0]               win_count
`endif
);

   localparam int NPIX     = IMG_W * IMG_H;
   localparam int WORDS    = NPIX / PIX_PER_WORD;
   localparam int PIX_AW   = $clog2(NPIX);
   localparam int WORD_AW  = $clog2(WORDS);
   localparam int LAST_ROW = IMG_H - WIN;
   localparam int LAST_COL = IMG_W - WIN;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_FILL,
      S_PRESENT
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [WORD_AW-1:0]  rd_k;
   logic                cap_vld;
   logic [WORD_AW-1:0]  cap_k;
   logic                last_win;
   logic                xfer;
   logic                start_ok;
   logic [PIX_W-1:0]    pix_buf [NPIX];

   // Handshake: a window transfers on a rising clk edge where window_valid and window_ready
   // are both high; window_data/win_row/win_col hold steady while valid waits for ready.
   assign last_win = (win_row == 7'(LAST_ROW)) && (win_col == 7'(LAST_COL));
   assign xfer     = (state == S_PRESENT) && window_ready;
   assign start_ok = (state == S_IDLE) && start && !abort;

   function automatic logic [PIX_AW-1:0] pix_index(input logic [6:0] row, input logic [6:0] col,
                                                    input int r, input int c);
      return PIX_AW'((int'(row) + r) * IMG_W + int'(col) + c);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:    if (start) state_next = S_LOAD;
         S_LOAD:    if (rd_k == WORD_AW'(WORDS - 1)) state_next = S_DRAIN;
         S_DRAIN:   state_next = S_FILL;
         S_FILL:    state_next = S_PRESENT;
         S_PRESENT: if (window_ready) state_next = last_win ? S_IDLE : S_FILL;
         default:   state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd_en    <= 1'b0;
         mem_addr     <= '0;
         window_valid <= 1'b0;
         window_data  <= '0;
         win_row      <= '0;
         win_col      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rd_k         <= '0;
         cap_vld      <= 1'b0;
         cap_k        <= '0;
      end else begin
         mem_rd_en    <= (state_next == S_LOAD);
         window_valid <= (state_next == S_PRESENT);
         busy         <= (state_next != S_IDLE);
         done         <= xfer && last_win && !abort;
         // The word addressed this cycle returns next cycle; remember where it goes.
         cap_vld      <= mem_rd_en;
         cap_k        <= rd_k;
         if (start_ok) begin
            mem_addr <= base_addr;
            rd_k     <= '0;
            win_row  <= '0;
            win_col  <= '0;
         end else if (state == S_LOAD && rd_k != WORD_AW'(WORDS - 1)) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            rd_k     <= rd_k + WORD_AW'(1);
         end
         if (state == S_FILL) begin
            for (int r = 0; r < WIN; r++)
               for (int c = 0; c < WIN; c++)
                  window_data[(r*WIN + c)*PIX_W +: PIX_W] <= pix_buf[pix_index(win_row, win_col, r, c)];
         end
         if (xfer && !last_win) begin
            if (win_col == 7'(LAST_COL)) begin
               win_col <= '0;
               win_row <= win_row + 7'(STRIDE);
            end else begin
               win_col <= win_col + 7'(STRIDE);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_vld) begin
         for (int j = 0; j < PIX_PER_WORD; j++)
            pix_buf[PIX_AW'(int'(cap_k) * PIX_PER_WORD + j)] <= mem_rd_data[j*PIX_W +: PIX_W];
      end
   end

`ifdef WINDOW_STREAMER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              win_count <= '0;
      else if (start_ok)                       win_count <= '0;
      else if (xfer && win_count != 16'hFFFF)  win_count <= win_count + 16'd1;
   end
`endif

endmodule
